// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, instruction geometry and the
// OFFSET field position that fetch and decode both rely on.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        ISSUE
    } fetch_state_t;

    localparam int INSTR_W   = 32;
    localparam int PC_STEP   = 4;
    localparam int OFFSET_HI = 23;
    localparam int OFFSET_LO = 16;
    localparam int OFFSET_W  = OFFSET_HI - OFFSET_LO + 1;

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC adder: sequential PC+4, or PC+4 plus a signed word offset on
// a taken branch or jump. All arithmetic wraps modulo 2^32.
module pc_next_calc
    import cpu_pkg::*;
(
    input  logic [31:0]         pc_i,
    input  logic [OFFSET_W-1:0] offset_i,
    input  logic                branch_taken_i,
    input  logic                jump_i,
    output logic [31:0]         next_pc_o
);

    logic [31:0] seq_pc;
    logic [31:0] off_bytes;

    assign seq_pc    = pc_i + 32'(PC_STEP);
    // Word offset -> byte offset, sign-extended to the PC width.
    assign off_bytes = {{(32 - OFFSET_W - 2){offset_i[OFFSET_W-1]}},
                        offset_i, 2'b00};

    assign next_pc_o = (branch_taken_i || jump_i) ? seq_pc + off_bytes
                                                  : seq_pc;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, reads instruction memory through busywait
// stalls and hands a latched instruction plus valid flag to decode.
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          IMEM_ADDR_W = 10
) (
    input  logic                   CLK,
    input  logic                   RESET,
    output logic                   IMEM_READ,
    output logic [IMEM_ADDR_W-1:0] IMEM_ADDRESS,
    input  logic [INSTR_W-1:0]     IMEM_READDATA,
    input  logic                   IMEM_BUSYWAIT,
    output logic [INSTR_W-1:0]     INSTRUCTION,
    output logic                   INSTR_VALID,
    output logic [31:0]            PC,
    input  logic [OFFSET_W-1:0]    OFFSET,
    input  logic                   BRANCH_TAKEN,
    input  logic                   JUMP,
    input  logic                   STALL
);

    fetch_state_t       state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [31:0]        next_pc;

    pc_next_calc u_pc_next_calc (
        .pc_i           (pc_q),
        .offset_i       (OFFSET),
        .branch_taken_i (BRANCH_TAKEN),
        .jump_i         (JUMP),
        .next_pc_o      (next_pc)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        unique case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (!IMEM_BUSYWAIT) begin
                    instr_d = IMEM_READDATA;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // Control inputs only matter on the edge that retires.
                if (!STALL) begin
                    pc_d    = next_pc;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign IMEM_READ    = (state_q == FETCH);
    assign INSTR_VALID  = (state_q == ISSUE);
    assign IMEM_ADDRESS = pc_q[IMEM_ADDR_W+1:2];
    assign INSTRUCTION  = instr_q;
    assign PC           = pc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed checks of the fetch stage followed by a randomized run
// scored against a queue of expected (PC, instruction) pairs.
module tb_instruction_fetch;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        IMEM_READ;
    logic [9:0]  IMEM_ADDRESS;
    logic [31:0] IMEM_READDATA;
    logic        IMEM_BUSYWAIT;
    logic [31:0] INSTRUCTION;
    logic        INSTR_VALID;
    logic [31:0] PC;
    logic [7:0]  OFFSET;
    logic        BRANCH_TAKEN;
    logic        JUMP;
    logic        STALL;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          issues = 0;
    bit          sb_en  = 1'b0;
    logic [31:0] mpc;

    instruction_fetch #(
        .RESET_PC    (32'h0000_0000),
        .IMEM_ADDR_W (10)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .IMEM_READ     (IMEM_READ),
        .IMEM_ADDRESS  (IMEM_ADDRESS),
        .IMEM_READDATA (IMEM_READDATA),
        .IMEM_BUSYWAIT (IMEM_BUSYWAIT),
        .INSTRUCTION   (INSTRUCTION),
        .INSTR_VALID   (INSTR_VALID),
        .PC            (PC),
        .OFFSET        (OFFSET),
        .BRANCH_TAKEN  (BRANCH_TAKEN),
        .JUMP          (JUMP),
        .STALL         (STALL)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [9:0] a);
        return (32'(a) * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic monitor();
        exp_t cur;
        bit   prev_v;
        prev_v = 1'b0;
        cur    = '{32'h0, 32'h0};
        forever begin
            @(negedge CLK);
            if (sb_en) begin
                if (INSTR_VALID && !prev_v) begin
                    issues++;
                    if (q.size() == 0) begin
                        chk("sb_empty", 32'd1, 32'd0);
                    end else begin
                        cur = q.pop_front();
                        chk("sb_pc", PC, cur.pc);
                        chk("sb_instr", INSTRUCTION, cur.ins);
                    end
                end else if (INSTR_VALID) begin
                    chk("sb_hold_pc", PC, cur.pc);
                    chk("sb_hold_instr", INSTRUCTION, cur.ins);
                end
                if (IMEM_READ && q.size() > 0)
                    chk("sb_addr", 32'(IMEM_ADDRESS), 32'(q[0].pc[11:2]));
                prev_v = INSTR_VALID;
            end else begin
                prev_v = 1'b0;
            end
        end
    endtask

    initial begin
        bit tk;
        RESET = 1'b1;
        IMEM_READDATA = 32'h0;
        IMEM_BUSYWAIT = 1'b0;
        OFFSET = 8'h00;
        BRANCH_TAKEN = 1'b0;
        JUMP = 1'b0;
        STALL = 1'b0;
        fork
            monitor();
        join_none

        repeat (2) @(negedge CLK);
        chk("rst_read", 32'(IMEM_READ), 32'd0);
        chk("rst_valid", 32'(INSTR_VALID), 32'd0);
        chk("rst_pc", PC, 32'h0);
        chk("rst_instr", INSTRUCTION, 32'h0);
        chk("rst_addr", 32'(IMEM_ADDRESS), 32'd0);

        IMEM_READDATA = 32'h0000_0105;
        RESET = 1'b0;
        step();
        chk("e1_read", 32'(IMEM_READ), 32'd1);
        chk("e1_addr", 32'(IMEM_ADDRESS), 32'd0);
        chk("e1_valid", 32'(INSTR_VALID), 32'd0);
        step();
        chk("e2_valid", 32'(INSTR_VALID), 32'd1);
        chk("e2_instr", INSTRUCTION, 32'h0000_0105);
        chk("e2_read", 32'(IMEM_READ), 32'd0);
        IMEM_READDATA = 32'h0000_0200;
        step();
        chk("e3_pc", PC, 32'd4);
        chk("e3_addr", 32'(IMEM_ADDRESS), 32'd1);
        step();
        chk("e4_instr", INSTRUCTION, 32'h0000_0200);

        IMEM_BUSYWAIT = 1'b1;
        IMEM_READDATA = 32'hBAD0_BAD0;
        step();
        for (int i = 0; i < 4; i++) begin
            chk("bw_read", 32'(IMEM_READ), 32'd1);
            chk("bw_addr", 32'(IMEM_ADDRESS), 32'd2);
            chk("bw_valid", 32'(INSTR_VALID), 32'd0);
            if (i == 3) begin
                IMEM_BUSYWAIT = 1'b0;
                IMEM_READDATA = 32'h0000_0300;
            end
            step();
        end
        chk("bw_done_valid", 32'(INSTR_VALID), 32'd1);
        chk("bw_done_instr", INSTRUCTION, 32'h0000_0300);
        chk("bw_done_pc", PC, 32'd8);

        OFFSET = 8'hFE;
        BRANCH_TAKEN = 1'b1;
        step();
        BRANCH_TAKEN = 1'b0;
        OFFSET = 8'h7F;
        chk("br_back_pc", PC, 32'd4);
        chk("br_back_addr", 32'(IMEM_ADDRESS), 32'd1);
        step();
        JUMP = 1'b1;
        OFFSET = 8'hFE;
        step();
        JUMP = 1'b0;
        chk("jmp_to0_pc", PC, 32'd0);
        step();
        BRANCH_TAKEN = 1'b1;
        step();
        BRANCH_TAKEN = 1'b0;
        chk("wrap_pc", PC, 32'hFFFF_FFFC);
        chk("wrap_addr", 32'(IMEM_ADDRESS), 32'h3FF);
        step();
        step();
        chk("wrap_seq_pc", PC, 32'd0);
        step();
        BRANCH_TAKEN = 1'b1;
        JUMP = 1'b1;
        OFFSET = 8'h7F;
        IMEM_READDATA = 32'h0000_0500;
        step();
        BRANCH_TAKEN = 1'b0;
        JUMP = 1'b0;
        chk("both_pc", PC, 32'd512);
        chk("both_addr", 32'(IMEM_ADDRESS), 32'd128);
        step();
        chk("both_instr", INSTRUCTION, 32'h0000_0500);

        STALL = 1'b1;
        BRANCH_TAKEN = 1'b1;
        OFFSET = 8'h01;
        IMEM_READDATA = 32'h0000_0600;
        step();
        chk("stall1_valid", 32'(INSTR_VALID), 32'd1);
        chk("stall1_pc", PC, 32'd512);
        chk("stall1_instr", INSTRUCTION, 32'h0000_0500);
        BRANCH_TAKEN = 1'b0;
        step();
        chk("stall2_valid", 32'(INSTR_VALID), 32'd1);
        chk("stall2_pc", PC, 32'd512);
        chk("stall2_instr", INSTRUCTION, 32'h0000_0500);
        STALL = 1'b0;
        step();
        chk("unstall_pc", PC, 32'd516);
        chk("unstall_read", 32'(IMEM_READ), 32'd1);

        IMEM_BUSYWAIT = 1'b1;
        @(posedge CLK);
        #2 RESET = 1'b1;
        #1;
        chk("arst_read", 32'(IMEM_READ), 32'd0);
        chk("arst_valid", 32'(INSTR_VALID), 32'd0);
        chk("arst_pc", PC, 32'd0);
        #1 RESET = 1'b0;
        IMEM_BUSYWAIT = 1'b0;
        IMEM_READDATA = 32'hDEAD_BEEF;
        @(negedge CLK);
        step();
        chk("late_instr", INSTRUCTION, 32'h0);
        chk("late_valid", 32'(INSTR_VALID), 32'd0);
        chk("late_read", 32'(IMEM_READ), 32'd1);
        step();
        chk("refetch_instr", INSTRUCTION, 32'hDEAD_BEEF);
        chk("refetch_pc", PC, 32'd0);

        RESET = 1'b1;
        step();
        q.delete();
        mpc = 32'h0;
        q.push_back('{mpc, mem_word(mpc[11:2])});
        sb_en = 1'b1;
        RESET = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge CLK);
            if (IMEM_READ && $urandom_range(0, 9) < 4) begin
                IMEM_BUSYWAIT = 1'b1;
                IMEM_READDATA = $urandom;
            end else if (IMEM_READ) begin
                IMEM_BUSYWAIT = 1'b0;
                IMEM_READDATA = mem_word(IMEM_ADDRESS);
            end else begin
                IMEM_BUSYWAIT = ($urandom_range(0, 1) == 1);
                IMEM_READDATA = $urandom;
            end
            STALL = ($urandom_range(0, 9) < 3);
            OFFSET = 8'($urandom);
            BRANCH_TAKEN = ($urandom_range(0, 3) == 0);
            JUMP = ($urandom_range(0, 5) == 0);
            if (INSTR_VALID && !STALL) begin
                tk = BRANCH_TAKEN || JUMP;
                mpc = mpc + 32'(4 + (tk ? 4 * int'($signed(OFFSET)) : 0));
                q.push_back('{mpc, mem_word(mpc[11:2])});
            end
        end
        @(posedge CLK);
        sb_en = 1'b0;
        checks++;
        if (issues < 100) begin
            errors++;
            $display("FAIL issue_count actual=%0d expected>=100", issues);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

- Fetch stage of the single-issue CPU, directly upstream of the instruction decoder.
- Holds the program counter and issues word reads to the instruction memory/cache, waiting out busywait stalls.
- Latches the returned 32-bit instruction and presents it with a valid flag to decode.
- Computes the next PC (sequential, or branch/jump target from the 8-bit word offset) once the current instruction retires.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- IMEM_ADDR_W, 10, width of the instruction-memory word address
- CLK  input  1  clock; all state changes on rising edge
- RESET  input  1  asynchronous, active-high reset
- IMEM_READ  output  1  read request to instruction memory
- IMEM_ADDRESS  output  IMEM_ADDR_W  word address = PC[IMEM_ADDR_W+1:2]
- IMEM_READDATA  input  32  instruction word from memory
- IMEM_BUSYWAIT  input  1  memory not ready; read data invalid while high
- INSTRUCTION  output  32  latched instruction to decode
- INSTR_VALID  output  1  INSTRUCTION holds a live instruction
- PC  output  32  address of the instruction in INSTRUCTION
- OFFSET  input  8  signed word offset from decode (INSTRUCTION[23:16])
- BRANCH_TAKEN  input  1  conditional branch resolved taken
- JUMP  input  1  unconditional jump
- STALL  input  1  back-end not ready (e.g. data-memory busywait); hold current instruction

## Operation
- States: IDLE, FETCH, ISSUE. Reset state is IDLE.
- IDLE: all outputs inactive; next edge moves to FETCH.
- FETCH: IMEM_READ=1 and IMEM_ADDRESS driven from PC.
  - Stay in FETCH while IMEM_BUSYWAIT=1.
  - On an edge with IMEM_BUSYWAIT=0, latch IMEM_READDATA into INSTRUCTION and go to ISSUE.
  - The memory raises IMEM_BUSYWAIT in the same cycle IMEM_READ rises on a miss; that is the memory's contract.
- ISSUE: INSTR_VALID=1, IMEM_READ=0.
  - If STALL=1, hold: INSTRUCTION, PC and state unchanged.
  - If STALL=0, PC ← next PC and go to FETCH.
- Next PC:
  - target = PC + 4 + (sign_extend(OFFSET) << 2) when BRANCH_TAKEN or JUMP is high.
  - Otherwise PC + 4.
- Arithmetic: all PC arithmetic is 32-bit modulo 2^32; 0xFFFF_FFFC + 4 wraps to 0.
- OFFSET range is −128..+127 words.
- BRANCH_TAKEN and JUMP both high: same target, no error.
- BRANCH_TAKEN, JUMP, OFFSET and STALL are ignored outside ISSUE; they are sampled only at the edge that leaves ISSUE.
- Reset values: PC=RESET_PC, INSTRUCTION=32'h0, INSTR_VALID=0, IMEM_READ=0, IMEM_ADDRESS=RESET_PC[IMEM_ADDR_W+1:2].
- RESET asserted in any state takes effect immediately, without waiting for a clock edge:
  - IMEM_READ drops in the same cycle.
  - An in-flight read is abandoned; a late response is not latched.

## Timing
- After reset release: edge 1 enters FETCH.
- With zero busywait, edge 2 latches the instruction and enters ISSUE.
- Steady state is 2 cycles per instruction (FETCH, ISSUE), plus 1 cycle per busywait cycle, plus 1 cycle per STALL cycle.
- Outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- INSTRUCTION and PC are stable for the whole ISSUE period, including while stalled.
- IMEM_ADDRESS is stable for the whole FETCH period.
- Redirect penalty is zero: the target is fetched in the FETCH immediately following ISSUE.

## Structure
- Shared package cpu_pkg holds:
  - the fetch_state_t enum (IDLE, FETCH, ISSUE)
  - INSTR_W=32
  - PC_STEP=4
  - the OFFSET field bounds [23:16], shared with decode
- One combinational sub-module, pc_next_calc: inputs PC, OFFSET, BRANCH_TAKEN, JUMP; output next PC.
- State register, PC, instruction register and valid flag live in instruction_fetch.

## Test plan
- Reset, RESET_PC=0, IMEM_BUSYWAIT=0, IMEM_READDATA=32'h0000_0105 → edge 1: IMEM_READ=1, IMEM_ADDRESS=0. Edge 2: INSTR_VALID=1, INSTRUCTION=32'h0000_0105. Next edge: PC=4.
- IMEM_BUSYWAIT high 3 cycles in FETCH at PC=8 → IMEM_READ held and IMEM_ADDRESS=2 for 4 cycles. INSTR_VALID=0 until the edge after busywait drops.
- PC=8, OFFSET=8'hFE, BRANCH_TAKEN=1 in ISSUE → next FETCH at PC=4. Then PC=0, OFFSET=8'h7F, JUMP=1 → PC=512. PC=0xFFFF_FFFC sequential → PC=0.
- STALL=1 for 2 cycles in ISSUE with BRANCH_TAKEN toggling → INSTRUCTION, PC and INSTR_VALID=1 unchanged. Only the BRANCH_TAKEN value at the STALL=0 edge decides the next PC.
- RESET pulsed mid-cycle during FETCH with busywait high → IMEM_READ=0 and INSTR_VALID=0 before the next edge. PC=RESET_PC. A memory response after release is not latched until a new FETCH.
